// File: rtl/color_classifier_pkg.sv
// Shared types for the colour classifier: FSM state encoding and the
// similarity grades reported on similar_flag / stable_flag.
package color_classifier_pkg;

  // Classifier sequencing: IDLE -> SCAN -> JUDGE -> REPORT -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_JUDGE  = 2'd2,
    ST_REPORT = 2'd3
  } cc_state_e;

  // Similarity grades of the best distance against the tolerance
  localparam logic [1:0] SIM_NONE = 2'b00;  // dist >  2*tol
  localparam logic [1:0] SIM_NEAR = 2'b01;  // tol < dist <= 2*tol
  localparam logic [1:0] SIM_HIT  = 2'b10;  // dist <= tol

  // Width of the consecutive-result counter (STABLE_N is at most 15)
  localparam int STAB_CW = 4;

endpackage

// File: rtl/color_classifier_l1_dist.sv
// L1 (Manhattan) distance between two RGB triples. The result is two bits
// wider than a channel so that three full-scale differences cannot overflow.
module color_l1_dist #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] i_a_r,
  input  logic [DW-1:0] i_a_g,
  input  logic [DW-1:0] i_a_b,
  input  logic [DW-1:0] i_b_r,
  input  logic [DW-1:0] i_b_g,
  input  logic [DW-1:0] i_b_b,
  output logic [DW+1:0] o_dist
);

  logic [DW-1:0] w_dr;
  logic [DW-1:0] w_dg;
  logic [DW-1:0] w_db;

  // Per-channel absolute difference, then widened sum
  always_comb begin
    w_dr = (i_a_r >= i_b_r) ? (i_a_r - i_b_r) : (i_b_r - i_a_r);
    w_dg = (i_a_g >= i_b_g) ? (i_a_g - i_b_g) : (i_b_g - i_a_g);
    w_db = (i_a_b >= i_b_b) ? (i_a_b - i_b_b) : (i_b_b - i_a_b);
    o_dist = (DW+2)'(w_dr) + (DW+2)'(w_dg) + (DW+2)'(w_db);
  end

endmodule

// File: rtl/color_classifier.sv
// Colour classifier: compares a sensor RGB sample against a small table of
// reference colours, one entry per cycle, reports the nearest valid entry
// with a similarity grade, and commits a stable result once the same
// {index, grade} has been seen STABLE_N times in a row.
module color_classifier
  import color_classifier_pkg::*;
#(
  parameter int  DW       = 8,
  parameter int  NREF     = 4,
  parameter int  STABLE_N = 3,
  localparam int IW       = $clog2(NREF),
  localparam int DSW      = DW + 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           sample_valid,
  input  logic [DW-1:0]  data_r,
  input  logic [DW-1:0]  data_g,
  input  logic [DW-1:0]  data_b,
  input  logic [DW-1:0]  tol,
  input  logic           ref_wr_en,
  input  logic [IW-1:0]  ref_wr_idx,
  input  logic [DW-1:0]  ref_wr_r,
  input  logic [DW-1:0]  ref_wr_g,
  input  logic [DW-1:0]  ref_wr_b,
  input  logic           ref_clr,
  output logic           ref_wr_err,
  output logic           busy,
  output logic           match_valid,
  output logic [IW-1:0]  match_idx,
  output logic [DSW-1:0] match_dist,
  output logic [1:0]     similar_flag,
  output logic [IW-1:0]  stable_idx,
  output logic [1:0]     stable_flag,
  output logic           stable_upd
);

  localparam logic [IW-1:0]      LAST_IDX   = IW'(NREF - 1);
  localparam logic [STAB_CW-1:0] STABLE_CNT = STAB_CW'(STABLE_N);

  // FSM
  cc_state_e r_state;
  cc_state_e w_state_nxt;
  logic      w_idle;
  logic      w_start;
  logic      w_judge;
  logic      w_scan_last;

  // Latched sample and tolerance
  logic [DW-1:0] r_smp_r;
  logic [DW-1:0] r_smp_g;
  logic [DW-1:0] r_smp_b;
  logic [DW-1:0] r_tol;

  // Reference table
  logic [DW-1:0]   r_ref_r [NREF];
  logic [DW-1:0]   r_ref_g [NREF];
  logic [DW-1:0]   r_ref_b [NREF];
  logic [NREF-1:0] r_ref_vld;

  // Scan state
  logic [IW-1:0]  r_scan_idx;
  logic [DSW-1:0] r_best_dist;
  logic [IW-1:0]  r_best_idx;
  logic           r_found;
  logic [DW-1:0]  w_cur_r;
  logic [DW-1:0]  w_cur_g;
  logic [DW-1:0]  w_cur_b;
  logic [DSW-1:0] w_cur_dist;
  logic           w_cur_better;

  // Judge results
  logic [DSW-1:0] w_tol_ext;
  logic [DSW-1:0] w_tol2;
  logic [IW-1:0]  w_res_idx;
  logic [DSW-1:0] w_res_dist;
  logic [1:0]     w_res_flag;

  // Stability tracking
  logic [STAB_CW-1:0] r_stab_cnt;
  logic [STAB_CW-1:0] w_cnt_nxt;
  logic               w_same_key;
  logic               w_commit;

  // Entry currently under evaluation
  assign w_cur_r = r_ref_r[r_scan_idx];
  assign w_cur_g = r_ref_g[r_scan_idx];
  assign w_cur_b = r_ref_b[r_scan_idx];

  color_l1_dist #(
    .DW(DW)
  ) u_dist (
    .i_a_r  (r_smp_r),
    .i_a_g  (r_smp_g),
    .i_a_b  (r_smp_b),
    .i_b_r  (w_cur_r),
    .i_b_g  (w_cur_g),
    .i_b_b  (w_cur_b),
    .o_dist (w_cur_dist)
  );

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and phase decodes
  always_comb begin
    w_state_nxt = r_state;
    w_idle      = 1'b0;
    w_start     = 1'b0;
    w_judge     = 1'b0;
    w_scan_last = (r_scan_idx == LAST_IDX);
    case (r_state)
      ST_IDLE: begin
        w_idle = 1'b1;
        if (sample_valid) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_scan_last) begin
          w_state_nxt = ST_JUDGE;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_JUDGE: begin
        w_judge     = 1'b1;
        w_state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Busy mirrors "not idle" one cycle ahead so it is itself a flop
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (w_state_nxt != ST_IDLE);
    end
  end

  // Reference table update: idle only, clear takes precedence over write
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ref_vld <= '0;
      for (int i = 0; i < NREF; i++) begin
        r_ref_r[i] <= '0;
        r_ref_g[i] <= '0;
        r_ref_b[i] <= '0;
      end
    end else if (w_idle && ref_clr) begin
      r_ref_vld <= '0;
    end else if (w_idle && ref_wr_en) begin
      r_ref_r[ref_wr_idx]   <= ref_wr_r;
      r_ref_g[ref_wr_idx]   <= ref_wr_g;
      r_ref_b[ref_wr_idx]   <= ref_wr_b;
      r_ref_vld[ref_wr_idx] <= 1'b1;
    end
  end

  // Table access attempted while a classification is in flight is refused
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ref_wr_err <= 1'b0;
    end else begin
      ref_wr_err <= !w_idle && (ref_wr_en || ref_clr);
    end
  end

  // Candidate wins only when valid and strictly closer (ties keep lower index)
  always_comb begin
    w_cur_better = r_ref_vld[r_scan_idx] && (w_cur_dist < r_best_dist);
  end

  // Sample latch and sequential nearest-entry search
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_smp_r     <= '0;
      r_smp_g     <= '0;
      r_smp_b     <= '0;
      r_tol       <= '0;
      r_scan_idx  <= '0;
      r_best_dist <= '1;
      r_best_idx  <= '0;
      r_found     <= 1'b0;
    end else if (w_start) begin
      r_smp_r     <= data_r;
      r_smp_g     <= data_g;
      r_smp_b     <= data_b;
      r_tol       <= tol;
      r_scan_idx  <= '0;
      r_best_dist <= '1;
      r_best_idx  <= '0;
      r_found     <= 1'b0;
    end else if (r_state == ST_SCAN) begin
      if (w_cur_better) begin
        r_best_dist <= w_cur_dist;
        r_best_idx  <= r_scan_idx;
        r_found     <= 1'b1;
      end
      if (!w_scan_last) begin
        r_scan_idx <= r_scan_idx + {{(IW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Grade the best distance; tolerance doubled at full width, no saturation
  always_comb begin
    w_tol_ext  = DSW'(r_tol);
    w_tol2     = w_tol_ext << 1;
    w_res_idx  = r_best_idx;
    w_res_dist = r_best_dist;
    w_res_flag = SIM_NONE;
    if (!r_found) begin
      w_res_idx  = '0;
      w_res_dist = '1;
      w_res_flag = SIM_NONE;
    end else if (r_best_dist <= w_tol_ext) begin
      w_res_flag = SIM_HIT;
    end else if (r_best_dist <= w_tol2) begin
      w_res_flag = SIM_NEAR;
    end else begin
      w_res_flag = SIM_NONE;
    end
  end

  // Run length of identical results and commit decision; the held match
  // outputs are the previous report's key
  always_comb begin
    w_same_key = (r_stab_cnt != '0) &&
                 (w_res_idx == match_idx) && (w_res_flag == similar_flag);
    if (!w_same_key) begin
      w_cnt_nxt = STAB_CW'(1);
    end else if (r_stab_cnt >= STABLE_CNT) begin
      w_cnt_nxt = STABLE_CNT;
    end else begin
      w_cnt_nxt = r_stab_cnt + STAB_CW'(1);
    end
    w_commit = (w_cnt_nxt == STABLE_CNT) &&
               ((w_res_idx != stable_idx) || (w_res_flag != stable_flag));
  end

  // Report registers: loaded at JUDGE so they are valid during REPORT
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      match_valid  <= 1'b0;
      match_idx    <= '0;
      match_dist   <= '1;
      similar_flag <= SIM_NONE;
      stable_idx   <= '0;
      stable_flag  <= SIM_NONE;
      stable_upd   <= 1'b0;
      r_stab_cnt   <= '0;
    end else begin
      match_valid <= w_judge;
      stable_upd  <= w_judge && w_commit;
      if (w_judge) begin
        match_idx    <= w_res_idx;
        match_dist   <= w_res_dist;
        similar_flag <= w_res_flag;
        r_stab_cnt   <= w_cnt_nxt;
        if (w_commit) begin
          stable_idx  <= w_res_idx;
          stable_flag <= w_res_flag;
        end
      end
    end
  end

endmodule

// File: tb/tb_color_classifier.sv
// Self-checking bench for color_classifier (DW=8, NREF=4, STABLE_N=3).
// Directed scenarios plus a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_color_classifier;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       sample_valid;
  logic [7:0] data_r, data_g, data_b, tol;
  logic       ref_wr_en;
  logic [1:0] ref_wr_idx;
  logic [7:0] ref_wr_r, ref_wr_g, ref_wr_b;
  logic       ref_clr;
  logic       ref_wr_err, busy, match_valid, stable_upd;
  logic [1:0] match_idx, similar_flag, stable_idx, stable_flag;
  logic [9:0] match_dist;

  int total = 0;
  int bad   = 0;

  // Behavioural model: table contents and stability history
  int m_vld[4];
  int m_r[4], m_g[4], m_b[4];
  int m_run, m_last, m_stable;

  // Last observed transaction and the model's expectation for it
  int         o_lat, o_nmv;
  logic [1:0] o_idx, o_flag, o_sidx, o_sflag;
  logic [9:0] o_dist;
  logic       o_upd;
  int         x_idx, x_dist, x_flag, x_upd;

  color_classifier #(.DW(8), .NREF(4), .STABLE_N(3)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sample_valid(sample_valid),
    .data_r(data_r), .data_g(data_g), .data_b(data_b), .tol(tol),
    .ref_wr_en(ref_wr_en), .ref_wr_idx(ref_wr_idx),
    .ref_wr_r(ref_wr_r), .ref_wr_g(ref_wr_g), .ref_wr_b(ref_wr_b),
    .ref_clr(ref_clr), .ref_wr_err(ref_wr_err), .busy(busy),
    .match_valid(match_valid), .match_idx(match_idx), .match_dist(match_dist),
    .similar_flag(similar_flag), .stable_idx(stable_idx),
    .stable_flag(stable_flag), .stable_upd(stable_upd)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int absd(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Nearest valid entry by brute force over the model table
  function automatic void model_classify(input int r, input int g, input int b, input int t);
    int d;
    bit found;
    found = 1'b0; x_idx = 0; x_dist = 1023; x_flag = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_vld[i] != 0) begin
        d = absd(r, m_r[i]) + absd(g, m_g[i]) + absd(b, m_b[i]);
        if (d < x_dist) begin
          x_dist = d; x_idx = i; found = 1'b1;
        end
      end
    end
    if (found) begin
      if (x_dist <= t) x_flag = 2;
      else if (x_dist <= 2 * t) x_flag = 1;
      else x_flag = 0;
    end
  endfunction

  // Commit when the trailing run of identical results is long enough and new
  function automatic void model_stable(input int idx, input int flag);
    int key;
    key = idx * 4 + flag;
    if (m_run > 0 && key == m_last) m_run++;
    else m_run = 1;
    m_last = key;
    x_upd = 0;
    if (m_run >= 3 && key != m_stable) begin
      m_stable = key;
      x_upd = 1;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_vld[i] = 0;
  endfunction

  function automatic void model_write(input int i, input int r, input int g, input int b);
    m_vld[i] = 1; m_r[i] = r; m_g[i] = g; m_b[i] = b;
  endfunction

  task automatic idle_inputs();
    sample_valid = 1'b0; ref_wr_en = 1'b0; ref_clr = 1'b0;
    data_r = 8'd0; data_g = 8'd0; data_b = 8'd0; tol = 8'd0;
    ref_wr_idx = 2'd0; ref_wr_r = 8'd0; ref_wr_g = 8'd0; ref_wr_b = 8'd0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    model_clear();
    for (int i = 0; i < 4; i++) begin
      m_r[i] = 0; m_g[i] = 0; m_b[i] = 0;
    end
    m_run = 0; m_last = -1; m_stable = 0;
  endtask

  task automatic wr_entry(input int i, input int r, input int g, input int b);
    ref_wr_en = 1'b1; ref_wr_idx = i[1:0];
    ref_wr_r = r[7:0]; ref_wr_g = g[7:0]; ref_wr_b = b[7:0];
    @(negedge sys_clk);
    ref_wr_en = 1'b0;
    model_write(i, r, g, b);
  endtask

  task automatic clear_table();
    ref_clr = 1'b1;
    @(negedge sys_clk);
    ref_clr = 1'b0;
    model_clear();
  endtask

  // One sample (optionally with a same-cycle table write/clear), observed
  // over a fixed 10-cycle window; fills o_* and the model's x_*
  task automatic do_sample(input int r, input int g, input int b, input int t,
                           input bit we, input int wi, input int wr, input int wg,
                           input int wb, input bit clr);
    sample_valid = 1'b1; data_r = r[7:0]; data_g = g[7:0]; data_b = b[7:0]; tol = t[7:0];
    ref_wr_en = we; ref_wr_idx = wi[1:0];
    ref_wr_r = wr[7:0]; ref_wr_g = wg[7:0]; ref_wr_b = wb[7:0]; ref_clr = clr;
    if (clr) model_clear();
    else if (we) model_write(wi, wr, wg, wb);
    model_classify(r, g, b, t);
    model_stable(x_idx, x_flag);
    o_lat = -1; o_nmv = 0; o_idx = 2'd0; o_dist = 10'd0; o_flag = 2'd0;
    o_upd = 1'b0; o_sidx = 2'd0; o_sflag = 2'd0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge sys_clk);
      sample_valid = 1'b0; ref_wr_en = 1'b0; ref_clr = 1'b0;
      if (match_valid === 1'b1) begin
        o_nmv++;
        if (o_lat < 0) begin
          o_lat = c; o_idx = match_idx; o_dist = match_dist; o_flag = similar_flag;
          o_upd = stable_upd; o_sidx = stable_idx; o_sflag = stable_flag;
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (match_dist !== 10'h3FF) begin
      bad++; $display("FAIL reset_dist got=%h want=3ff", match_dist);
    end
    total++;
    if ({match_valid, busy, ref_wr_err, stable_upd} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {match_valid, busy, ref_wr_err, stable_upd});
    end
    total++;
    if ({match_idx, similar_flag, stable_idx, stable_flag} !== 8'h00) begin
      bad++; $display("FAIL reset_fields got=%h want=00", {match_idx, similar_flag, stable_idx, stable_flag});
    end
  endtask

  task automatic test_hit();
    wr_entry(0, 255, 0, 0);
    wr_entry(1, 0, 255, 0);
    do_sample(250, 5, 3, 16, 1'b0, 0, 0, 0, 0, 1'b0);
    total++;
    if (o_lat !== 6) begin bad++; $display("FAIL hit_latency got=%0d want=6", o_lat); end
    total++;
    if (o_idx !== 2'd0) begin bad++; $display("FAIL hit_idx got=%0d want=0", o_idx); end
    total++;
    if (o_dist !== 10'd13) begin bad++; $display("FAIL hit_dist got=%0d want=13", o_dist); end
    total++;
    if (o_flag !== 2'b10) begin bad++; $display("FAIL hit_flag got=%b want=10", o_flag); end
    total++;
    if (o_nmv !== 1) begin bad++; $display("FAIL hit_pulses got=%0d want=1", o_nmv); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL hit_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_near();
    int tols[4];
    logic [1:0] want[4];
    tols[0] = 16; want[0] = 2'b00;
    tols[1] = 30; want[1] = 2'b01;
    tols[2] = 55; want[2] = 2'b10;   // dist == tol
    tols[3] = 27; want[3] = 2'b00;   // 2*tol == 54, one short
    for (int k = 0; k < 4; k++) begin
      do_sample(230, 20, 10, tols[k], 1'b0, 0, 0, 0, 0, 1'b0);
      total++;
      if (o_dist !== 10'd55) begin bad++; $display("FAIL near_dist tol=%0d got=%0d want=55", tols[k], o_dist); end
      total++;
      if (o_flag !== want[k]) begin bad++; $display("FAIL near_flag tol=%0d got=%b want=%b", tols[k], o_flag, want[k]); end
    end
  endtask

  task automatic test_tie();
    wr_entry(2, 100, 100, 100);
    wr_entry(0, 100, 100, 100);
    do_sample(100, 100, 100, 5, 1'b0, 0, 0, 0, 0, 1'b0);
    total++;
    if (o_idx !== 2'd0) begin bad++; $display("FAIL tie_idx got=%0d want=0", o_idx); end
    total++;
    if (o_dist !== 10'd0) begin bad++; $display("FAIL tie_dist got=%0d want=0", o_dist); end
  endtask

  task automatic test_stability();
    logic want;
    apply_reset();
    wr_entry(1, 40, 80, 120);
    for (int k = 0; k < 4; k++) begin
      do_sample(42, 80, 118, 10, 1'b0, 0, 0, 0, 0, 1'b0);
      want = (k == 2);
      total++;
      if (o_upd !== want) begin bad++; $display("FAIL stab_upd n=%0d got=%b want=%b", k + 1, o_upd, want); end
    end
    total++;
    if ({o_sidx, o_sflag} !== 4'b0110) begin
      bad++; $display("FAIL stab_commit got=%b want=0110", {o_sidx, o_sflag});
    end
    // A different result breaks the run; returning to the committed value
    // never pulses again
    do_sample(42, 80, 118, 1, 1'b0, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) do_sample(42, 80, 118, 10, 1'b0, 0, 0, 0, 0, 1'b0);
      total++;
      if (o_upd !== 1'b0) begin bad++; $display("FAIL stab_rerun n=%0d got=%b want=0", k, o_upd); end
    end
  endtask

  task automatic test_busy_reject();
    int nerr, nmv;
    nerr = 0; nmv = 0;
    sample_valid = 1'b1; data_r = 8'd139; data_g = 8'd0; data_b = 8'd0; tol = 8'd20;
    for (int c = 1; c <= 12; c++) begin
      @(negedge sys_clk);
      sample_valid = 1'b0; ref_wr_en = 1'b0;
      if (c == 2) begin
        sample_valid = 1'b1; data_r = 8'd0;
        ref_wr_en = 1'b1; ref_wr_idx = 2'd3;
        ref_wr_r = 8'd139; ref_wr_g = 8'd0; ref_wr_b = 8'd0;
      end
      if (ref_wr_err === 1'b1) nerr++;
      if (match_valid === 1'b1) nmv++;
    end
    total++;
    if (nerr !== 1) begin bad++; $display("FAIL busy_err_pulses got=%0d want=1", nerr); end
    total++;
    if (nmv !== 1) begin bad++; $display("FAIL busy_match_pulses got=%0d want=1", nmv); end
    do_sample(139, 0, 0, 20, 1'b0, 0, 0, 0, 0, 1'b0);
    total++;
    if (o_idx !== x_idx[1:0] || o_dist !== x_dist[9:0]) begin
      bad++; $display("FAIL busy_table_kept got=%0d/%0d want=%0d/%0d", o_idx, o_dist, x_idx, x_dist);
    end
  endtask

  task automatic test_clear_midreset();
    int nmv;
    clear_table();
    do_sample(10, 10, 10, 50, 1'b0, 0, 0, 0, 0, 1'b0);
    total++;
    if ({o_idx, o_flag, o_dist} !== {2'd0, 2'b00, 10'h3FF}) begin
      bad++; $display("FAIL clr_empty got=%0d/%b/%h want=0/00/3ff", o_idx, o_flag, o_dist);
    end
    // clear and write in the same cycle: clear wins
    do_sample(10, 10, 10, 50, 1'b1, 2, 10, 10, 10, 1'b1);
    total++;
    if (o_dist !== 10'h3FF) begin bad++; $display("FAIL clr_wins got=%h want=3ff", o_dist); end
    // write together with the sample: scan sees the new entry
    do_sample(10, 10, 10, 5, 1'b1, 3, 12, 10, 10, 1'b0);
    total++;
    if ({o_idx, o_dist, o_flag} !== {2'd3, 10'd2, 2'b10}) begin
      bad++; $display("FAIL wr_with_sample got=%0d/%0d/%b want=3/2/10", o_idx, o_dist, o_flag);
    end
    // reset in the middle of a scan
    sample_valid = 1'b1; data_r = 8'd12; data_g = 8'd10; data_b = 8'd10; tol = 8'd5;
    @(negedge sys_clk);
    sample_valid = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    nmv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge sys_clk);
      if (match_valid === 1'b1) nmv++;
    end
    total++;
    if (nmv !== 0) begin bad++; $display("FAIL midreset_pulses got=%0d want=0", nmv); end
    total++;
    if ({busy, match_idx, similar_flag, stable_idx, stable_flag, stable_upd, ref_wr_err} !== 11'd0 ||
        match_dist !== 10'h3FF) begin
      bad++; $display("FAIL midreset_outputs dist=%h busy=%b idx=%0d got nonreset want reset", match_dist, busy, match_idx);
    end
    apply_reset();
  endtask

  task automatic test_random();
    int pr[3], pg[3], pb[3], pt[3];
    int p, op;
    apply_reset();
    for (int i = 0; i < 4; i++)
      wr_entry(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    for (int i = 0; i < 3; i++) begin
      pr[i] = m_r[i] ^ $urandom_range(0, 15);
      pg[i] = m_g[i] ^ $urandom_range(0, 15);
      pb[i] = m_b[i] ^ $urandom_range(0, 15);
      pt[i] = $urandom_range(0, 40);
    end
    p = 0;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 19);
      if ($urandom_range(0, 2) == 0) p = $urandom_range(0, 2);
      if (op == 0) clear_table();
      else if (op <= 2) wr_entry($urandom_range(0, 3), $urandom_range(0, 255),
                                 $urandom_range(0, 255), $urandom_range(0, 255));
      if (op == 3)
        do_sample(pr[p], pg[p], pb[p], pt[p], 1'b1, $urandom_range(0, 3),
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
      else if (op == 4)
        do_sample(pr[p], pg[p], pb[p], pt[p], 1'b1, $urandom_range(0, 3), 1, 2, 3, 1'b1);
      else
        do_sample(pr[p], pg[p], pb[p], pt[p], 1'b0, 0, 0, 0, 0, 1'b0);
      total++;
      if (o_lat !== 6 || o_nmv !== 1) begin
        bad++; $display("FAIL rnd_timing it=%0d lat=%0d pulses=%0d want=6/1", it, o_lat, o_nmv);
      end
      total++;
      if ({o_idx, o_dist, o_flag} !== {x_idx[1:0], x_dist[9:0], x_flag[1:0]}) begin
        bad++; $display("FAIL rnd_result it=%0d got=%0d/%0d/%b want=%0d/%0d/%0d",
                        it, o_idx, o_dist, o_flag, x_idx, x_dist, x_flag);
      end
      total++;
      if (o_upd !== x_upd[0] || {o_sidx, o_sflag} !== m_stable[3:0]) begin
        bad++; $display("FAIL rnd_stable it=%0d got=%b/%b want=%0d/%b",
                        it, o_upd, {o_sidx, o_sflag}, x_upd, m_stable[3:0]);
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_hit();
    test_near();
    test_tie();
    test_stability();
    test_busy_reject();
    test_clear_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/color_classifier.md
COLOR_CLASSIFIER -- requirements
Module: color_classifier

Interface
REQ-001 SHALL have parameter DW, default 8, meaning RGB channel width.
REQ-002 SHALL have parameter NREF, default 4, meaning reference-colour table depth (2..16).
REQ-003 SHALL have parameter STABLE_N, default 3, meaning consecutive identical results required before commit (1..15).
REQ-004 SHALL derive IW = clog2(NREF) and distance width DSW = DW+2.
REQ-005 SHALL have ports:
- sys_clk  in  1  sole clock, rising edge.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- sample_valid  in  1  one-cycle strobe; data_r/g/b valid.
- data_r, data_g, data_b  in  DW each  sensor sample.
- tol  in  DW  match tolerance on L1 distance.
- ref_wr_en  in  1  table write strobe.
- ref_wr_idx  in  IW  table entry to write.
- ref_wr_r, ref_wr_g, ref_wr_b  in  DW each  reference colour.
- ref_clr  in  1  invalidate all entries.
- ref_wr_err  out  1  one-cycle pulse; write or clear rejected.
- busy  out  1  high outside IDLE.
- match_valid  out  1  one-cycle pulse per classified sample.
- match_idx  out  IW  nearest valid entry.
- match_dist  out  DSW  L1 distance to match_idx.
- similar_flag  out  2  00 none, 01 near (dist <= 2*tol), 10 hit (dist <= tol).
- stable_idx  out  IW  last committed index.
- stable_flag  out  2  last committed similar_flag.
- stable_upd  out  1  one-cycle pulse on commit change.

Function
REQ-006 SHALL implement FSM IDLE -> SCAN -> JUDGE -> REPORT -> IDLE.
REQ-007 IDLE: on sample_valid, SHALL latch the sample and tol, clear the best-distance register to all-ones, and enter SCAN.
REQ-008 SCAN: SHALL evaluate one entry per cycle, index 0..NREF-1, computing |dr|+|dg|+|db| at DSW bits with no overflow.
REQ-009 SCAN SHALL skip invalid entries, update best only on strictly smaller distance (tie -> lowest index), and exit to JUDGE after entry NREF-1.
REQ-010 JUDGE: SHALL compute similar_flag from best distance and latched tol; tol compare at DSW bits; 2*tol SHALL not saturate.
REQ-011 JUDGE: no valid entry -> match_idx 0, match_dist all-ones, similar_flag 00.
REQ-012 REPORT: SHALL pulse match_valid with match_idx/match_dist/similar_flag stable and held until the next REPORT.
REQ-013 Latency SHALL be exactly NREF+2 cycles from the sample_valid cycle to the match_valid cycle; busy high for those cycles.
REQ-014 sample_valid while busy SHALL be dropped with no side effects.
REQ-015 ref_wr_en or ref_clr in IDLE SHALL take effect next cycle; a write sets the entry valid.
REQ-016 ref_wr_en or ref_clr while busy SHALL be ignored and pulse ref_wr_err.
REQ-017 ref_clr and ref_wr_en in the same IDLE cycle: clear SHALL win and no entry is written.
REQ-018 sample_valid and a table write in the same IDLE cycle: the write SHALL apply first; the scan sees the new entry.
REQ-019 Stability: SHALL count consecutive REPORTs with identical {match_idx, similar_flag}; the counter saturates at STABLE_N.
REQ-020 On reaching STABLE_N with a value differing from {stable_idx, stable_flag}, SHALL update both and pulse stable_upd in the same cycle as match_valid.
REQ-021 A differing result SHALL reset the count to 1.

Reset
REQ-022 Reset SHALL force: FSM IDLE; all table entries invalid and zero; all outputs 0, except match_dist all-ones; stability count 0.
REQ-023 Reset mid-SCAN SHALL abort with no match_valid pulse afterwards.

Structure
REQ-024 A shared package SHALL hold the FSM state enum and the similar_flag encodings (NONE/NEAR/HIT).
REQ-025 SHALL contain one sub-module, color_l1_dist: combinational distance of two RGB triples, parametrised by DW.

Verification
REQ-026 Bench SHALL cover, with DW=8, NREF=4, STABLE_N=3:
- Write entries 0=(255,0,0), 1=(0,255,0); tol=16; sample (250,5,3) -> after 6 cycles: match_idx 0, match_dist 13, similar_flag 10.
- Sample (230,20,10), tol=16 -> dist 55, similar_flag 00; tol=30 -> similar_flag 01.
- Entries 0 and 2 both (100,100,100); sample (100,100,100) -> match_idx 0, dist 0.
- Same HIT sample sent 3 times -> stable_upd pulses on the third match_valid only; a fourth -> no pulse.
- ref_wr_en and a second sample_valid during busy -> ref_wr_err pulses, table unchanged, only one match_valid.
- ref_clr, then sample -> similar_flag 00, match_dist 0x3FF; reset asserted mid-SCAN -> no match_valid, all outputs at reset values.
